// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer
//   Instruction-fetch stage sitting between the PC generator and the IF/ID boundary.
//   An address offered by the PC stage is sent to the instruction ROM. The ROM has a
//   one-cycle registered read, so the word returns on the next cycle. It is paired with
//   its PC and queued in a DEPTH-entry FIFO. The FIFO head goes to decode through a
//   valid/ready handshake.
//
//   An offer is accepted only when a slot is guaranteed for it. The check counts both
//   the queued entries and the fetch still in flight. A pop in the same cycle does not
//   free a slot for that cycle's offer. Because of this, a returning word always finds
//   room and the FIFO can never overflow.
//
//   Flush discards all queued entries and the in-flight fetch. No new request is issued
//   in the flush cycle.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   pc_ce     PC stage offers pc_addr this cycle
//   pc_addr   address offered by PC stage
//   pc_stall  offer not accepted; PC stage must hold pc_addr
//   rom_ce    ROM read request (combinational)
//   rom_addr  ROM read address (equals pc_addr)
//   rom_data  ROM word, valid the cycle after rom_ce
//   flush     discard queued and in-flight fetches
//   id_ready  decode accepts head entry
//   id_valid  head entry valid
//   id_pc     PC of head entry (0 when empty)
//   id_inst   instruction of head entry (0 when empty)

module if_fetch_buffer #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_ce,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_stall,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              flush,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that a count of exactly DEPTH is representable.
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              inflight;
    logic [ADDR_W-1:0] req_pc;

    logic [CNT_W-1:0]  occupancy;
    logic              accept;
    logic              push;
    logic              pop;

    // Handshake and credit decode
    always_comb begin
        occupancy = count + {{(CNT_W-1){1'b0}}, inflight};
        // Gating with rst keeps rom_ce/pc_stall low while reset is held, even with no clock.
        accept    = rst & pc_ce & ~flush & (occupancy < DEPTH_C);
        // A word returning during a flush belongs to a squashed fetch.
        push      = inflight & ~flush;
        pop       = id_valid & id_ready;
    end

    always_comb begin
        rom_ce   = accept;
        rom_addr = pc_addr;
        pc_stall = rst & pc_ce & ~accept & ~flush;
        id_valid = (count != '0);
        id_pc    = id_valid ? pc_mem[rd_ptr] : '0;
        id_inst  = id_valid ? inst_mem[rd_ptr] : '0;
    end

    // Control state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            req_pc   <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                req_pc <= pc_addr;
            end

            if (flush) begin
                // Realigning the read pointer to the write pointer empties the queue.
                // No write happens this cycle, so wr_ptr stays where it is.
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage. It needs no reset because id_valid masks unwritten slots.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= req_pc;
            inst_mem[wr_ptr] <= rom_data;
        end
    end

    // Credit accounting guarantees that a returning word never lands on a full queue.
    assert property (@(posedge clk) disable iff (!rst) !(push && (count == DEPTH_C)))
        else $error("if_fetch_buffer: push into full queue");

    assert property (@(posedge clk) disable iff (!rst) count <= DEPTH_C)
        else $error("if_fetch_buffer: count exceeds DEPTH");

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              pc_ce;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_stall;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              flush;
    logic              id_ready;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_inst;

    int n_chk;
    int n_fail;

    if_fetch_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_ce    (pc_ce),
        .pc_addr  (pc_addr),
        .pc_stall (pc_stall),
        .rom_ce   (rom_ce),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .flush    (flush),
        .id_ready (id_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents are a fixed function of the address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'd7) ^ 32'h5A3C_0F96;
    endfunction

    // Registered-read ROM model.
    always_ff @(posedge clk) begin
        if (rom_ce) begin
            rom_data <= rom_word(rom_addr);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic [31:0] a, input logic fl, input logic rdy);
        pc_ce    = ce;
        pc_addr  = a;
        flush    = fl;
        id_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks outputs at the falling edge, then advances past the next rising edge.
    task automatic expect_out(input string nm, input logic e_rom, input logic e_stall,
                              input logic e_valid, input logic [31:0] e_pc);
        @(negedge clk);
        chk({nm, ".rom_ce"}, 32'(rom_ce), 32'(e_rom));
        chk({nm, ".pc_stall"}, 32'(pc_stall), 32'(e_stall));
        chk({nm, ".id_valid"}, 32'(id_valid), 32'(e_valid));
        chk({nm, ".id_pc"}, id_pc, e_valid ? e_pc : 32'h0);
        chk({nm, ".id_inst"}, id_inst, e_valid ? rom_word(e_pc) : 32'h0);
        tick();
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
    endtask

    // Reference model: a queue of fetched PCs plus one outstanding request.
    logic [31:0] mq[$];
    bit          m_infl;
    logic [31:0] m_req;

    task automatic model_reset();
        mq.delete();
        m_infl = 1'b0;
        m_req  = 32'h0;
    endtask

    task automatic model_expect(input logic ce, input logic fl,
                                output logic e_rom, output logic e_stall,
                                output logic e_valid, output logic [31:0] e_pc);
        e_rom   = ce && !fl && ((mq.size() + int'(m_infl)) < DEPTH);
        e_stall = ce && !e_rom && !fl;
        e_valid = (mq.size() != 0);
        e_pc    = e_valid ? mq[0] : 32'h0;
    endtask

    task automatic model_step(input logic ce, input logic [31:0] a, input logic fl,
                              input logic rdy);
        bit acc;
        acc = ce && !fl && ((mq.size() + int'(m_infl)) < DEPTH);
        if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_req);
        end
        m_infl = acc;
        if (acc) m_req = a;
    endtask

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic        fl;
        logic        rdy;
        logic        e_rom;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic        e_rom;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] got[$];
        int          nxt;

        n_chk  = 0;
        n_fail = 0;

        // Back-pressure (rows 0-8), then streaming with id_ready high (rows 9-15).
        vecs[0]  = '{1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8};
        vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        // Same-cycle pop is not credited, so 0x8 stalls once here.
        vecs[11] = '{1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8};
        vecs[15] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

        // Reset state, observed without any clock edge
        rst = 1'b0;
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        #2;
        chk("reset.rom_ce", 32'(rom_ce), 32'h0);
        chk("reset.pc_stall", 32'(pc_stall), 32'h0);
        chk("reset.id_valid", 32'(id_valid), 32'h0);
        chk("reset.id_pc", id_pc, 32'h0);
        chk("reset.id_inst", id_inst, 32'h0);
        #20;
        do_reset();

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].ce, vecs[i].addr, vecs[i].fl, vecs[i].rdy);
            expect_out($sformatf("vec%0d", i), vecs[i].e_rom, vecs[i].e_stall,
                       vecs[i].e_valid, vecs[i].e_pc);
        end

        // Flush while a fetch is in flight: the word for 0x10 is dropped
        do_reset();
        drive(1'b1, 32'h10, 1'b0, 1'b1); expect_out("fl_a", 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1);  expect_out("fl_b", 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h20, 1'b0, 1'b1); expect_out("fl_c", 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);  expect_out("fl_d", 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("fl_e", 1'b0, 1'b0, 1'b1, 32'h20);
        expect_out("fl_f", 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("fl_g", 1'b0, 1'b0, 1'b0, 32'h0);

        // Flush together with pc_ce on a full queue
        do_reset();
        drive(1'b1, 32'h40, 1'b0, 1'b0); expect_out("ff_a", 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h44, 1'b0, 1'b0); expect_out("ff_b", 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);  expect_out("ff_c", 1'b0, 1'b0, 1'b1, 32'h40);
        drive(1'b1, 32'h48, 1'b1, 1'b0); expect_out("ff_d", 1'b0, 1'b0, 1'b1, 32'h40);
        drive(1'b1, 32'h48, 1'b0, 1'b0); expect_out("ff_e", 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);  expect_out("ff_f", 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("ff_g", 1'b0, 1'b0, 1'b1, 32'h48);
        expect_out("ff_h", 1'b0, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset with two entries queued
        do_reset();
        drive(1'b1, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h4, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        #1;
        chk("arst.pre_valid", 32'(id_valid), 32'h1);
        chk("arst.pre_stall", 32'(pc_stall), 32'h1);
        rst = 1'b0;
        #1;
        chk("arst.id_valid", 32'(id_valid), 32'h0);
        chk("arst.rom_ce", 32'(rom_ce), 32'h0);
        chk("arst.pc_stall", 32'(pc_stall), 32'h0);
        chk("arst.id_pc", id_pc, 32'h0);
        chk("arst.id_inst", id_inst, 32'h0);
        rst = 1'b1;
        expect_out("arst.resume", 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        expect_out("arst.resume2", 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("arst.resume3", 1'b0, 1'b0, 1'b1, 32'h8);

        // Wrap-around: 12 fetches with id_ready toggling 1,0,1,0...
        do_reset();
        model_reset();
        nxt = 0;
        for (int cyc = 0; cyc < 200 && got.size() < 12; cyc++) begin
            logic        ce;
            logic        rdy;
            logic [31:0] a;
            ce  = (nxt < 12);
            a   = 32'(nxt * 4);
            rdy = ((cyc % 2) == 0);
            drive(ce, a, 1'b0, rdy);
            model_expect(ce, 1'b0, e_rom, e_stall, e_valid, e_pc);
            @(negedge clk);
            chk("wrap.rom_ce", 32'(rom_ce), 32'(e_rom));
            chk("wrap.pc_stall", 32'(pc_stall), 32'(e_stall));
            chk("wrap.id_valid", 32'(id_valid), 32'(e_valid));
            if (id_valid && rdy) got.push_back(id_pc);
            model_step(ce, a, 1'b0, rdy);
            if (e_rom) nxt++;
            tick();
        end
        chk("wrap.count", 32'(got.size()), 32'd12);
        for (int i = 0; i < got.size(); i++) begin
            chk($sformatf("wrap.pc%0d", i), got[i], 32'(i * 4));
        end

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic        ce;
            logic        fl;
            logic        rdy;
            logic [31:0] a;
            ce  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            a   = {22'($urandom_range(0, 1023)), 10'h0} | {22'h0, 8'($urandom), 2'b00};
            drive(ce, a, fl, rdy);
            model_expect(ce, fl, e_rom, e_stall, e_valid, e_pc);
            @(negedge clk);
            chk("rnd.rom_ce", 32'(rom_ce), 32'(e_rom));
            chk("rnd.pc_stall", 32'(pc_stall), 32'(e_stall));
            chk("rnd.rom_addr", rom_addr, a);
            chk("rnd.id_valid", 32'(id_valid), 32'(e_valid));
            chk("rnd.id_pc", id_pc, e_pc);
            chk("rnd.id_inst", id_inst, e_valid ? rom_word(e_pc) : 32'h0);
            model_step(ce, a, fl, rdy);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
